serial_subtractor_4bit: RTL and testbench

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

---
 rtl/serial_subtractor_4bit.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
// One operand set (A, B, Bin) is taken per input transfer. The difference is
// then computed LSB first, one bit per clock, through a single 1-bit full
// subtractor. The result is presented on Diff/Bout with out_valid and held
// until the consumer takes it.
//
// Timing: an input transfer at edge k raises out_valid from edge k+WIDTH.
// The result leaves at the next edge that sees out_ready=1, and the block is
// ready again one edge after that. Back-to-back throughput is therefore one
// result every WIDTH+2 cycles.
//
// Ports
//   clk        in   1      rising-edge clock for all state
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand set on A/B/Bin is valid
//   in_ready   out  1      block can accept operands (IDLE)
//   A          in   WIDTH  minuend, unsigned
//   B          in   WIDTH  subtrahend, unsigned
//   Bin        in   1      borrow-in
//   out_valid  out  1      Diff/Bout hold a completed result (DONE)
//   out_ready  in   1      consumer accepts the result
//   Diff       out  WIDTH  (A - B - Bin) mod 2^WIDTH
//   Bout       out  1      1 iff A < B + Bin
// ---------------------------------------------------------------------------
module serial_subtractor_4bit #(
  parameter int WIDTH = 4  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Control state and registered handshake outputs
  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;       // index of the bit processed at the next RUN edge

  // Datapath: operand shift registers, running borrow, partial result
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             br_q;
  // Only WIDTH-1 bits need storing: the final difference bit comes straight
  // from the subtractor on the last RUN edge.
  logic [WIDTH-2:0] res_sh_q;

  // Result registers visible on the outputs
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // One-bit full subtractor and the next view of the result register
  logic             d_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] full_res_d;  // partial result with the current bit on top
  logic [WIDTH-2:0] res_sh_d;

  // NOTE: every signal written here gets a value on every pass through the
  // block, so no latch can be inferred.
  always_comb begin
    d_bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_d       = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    // Difference bits enter at the MSB end and move down, so after the last
    // bit the register reads LSB-aligned.
    full_res_d = {d_bit_d, res_sh_q};
    res_sh_d   = full_res_d[WIDTH-1:1];
  end

  // Single FSM process: control, datapath and registered outputs together.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset clears the datapath and result registers too, not only the
    // control state. A reset that lands mid-operation therefore leaves no
    // stale partial result behind.
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      br_q        <= 1'b0;
      res_sh_q    <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Input transfer: take a private copy of the operands. Later
          // activity on A/B/Bin/in_valid cannot reach the computation.
          if (in_valid) begin
            a_sh_q     <= A;
            b_sh_q     <= B;
            br_q       <= Bin;
            cnt_q      <= '0;
            res_sh_q   <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end

        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          br_q     <= br_d;
          res_sh_q <= res_sh_d;
          cnt_q    <= cnt_q + CNT_ONE;
          // Last bit: publish the result. Diff/Bout change only here, so they
          // keep the previous result through IDLE and RUN.
          if (cnt_q == LAST_BIT) begin
            diff_q      <= full_res_d;
            bout_q      <= br_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          // Hold the result until the consumer takes it (backpressure).
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_4bit
//
// Self-checking bench for serial_subtractor_4bit (WIDTH=4). Expected results
// come from plain integer arithmetic: A - B - Bin computed as a signed int.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Bout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned subtraction as plain signed integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bin,
                                output logic [W-1:0] d, output logic bo);
    int r;
    r  = int'(a) - int'(b) - int'(bin);
    d  = W'(r);
    bo = (r < 0);
  endfunction

  // Runs one operation. Called at a falling edge and returns at the falling
  // edge right after the output transfer. xfer_at is the count of the edge
  // that took the operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int stall, input bit disturb, input bit keep_ready,
                        input string tag, output int xfer_at);
    logic [W-1:0] exp_d;
    logic         exp_b;
    int           wait_n;
    int           first_valid;
    model(a, b, bin, exp_d, exp_b);

    wait_n = 0;
    while (!in_ready && wait_n < 4 * W) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);

    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = keep_ready;
    @(negedge clk);                       // input transfer edge has passed
    xfer_at  = cyc;
    in_valid = disturb;
    if (disturb) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    end

    first_valid = 0;
    for (int j = 1; j <= W + 3 && first_valid == 0; j++) begin
      @(negedge clk);
      if (out_valid) first_valid = j;
      else if (disturb) begin
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end
    end
    check({tag, "_latency"}, 64'(first_valid), 64'(W));
    check({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_diff"}, 64'(Diff), 64'(exp_d));
    check({tag, "_bout"}, 64'(Bout), 64'(exp_b));

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_hold"}, 64'({out_valid, in_ready, Bout, Diff}),
            64'({1'b1, 1'b0, exp_b, exp_d}));
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);                       // output transfer edge has passed
    check({tag, "_release"}, 64'({out_valid, in_ready, Bout, Diff}),
          64'({1'b0, 1'b1, exp_b, exp_d}));
    out_ready = keep_ready;
  endtask

  initial begin
    int x;
    int prev;
    bit quiet;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", 64'({out_valid, in_ready, Bout, Diff}), 64'({1'b0, 1'b1, 1'b0, 4'b0000}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with known answers
    run_op(4'b0101, 4'b0011, 1'b0, 0, 1'b0, 1'b0, "basic", x);
    check("basic_const", 64'({Bout, Diff}), 64'({1'b0, 4'b0010}));
    run_op(4'b0011, 4'b0101, 1'b0, 0, 1'b0, 1'b0, "borrow", x);
    check("borrow_const", 64'({Bout, Diff}), 64'({1'b1, 4'b1110}));
    run_op(4'b0000, 4'b1111, 1'b1, 0, 1'b0, 1'b0, "wrap", x);
    check("wrap_const", 64'({Bout, Diff}), 64'({1'b1, 4'b0000}));
    run_op(4'b1111, 4'b0000, 1'b1, 0, 1'b0, 1'b0, "binmax", x);
    check("binmax_const", 64'({Bout, Diff}), 64'({1'b0, 4'b1110}));

    // Backpressure: three cycles of out_ready=0 in DONE
    run_op(4'b1100, 4'b0110, 1'b1, 3, 1'b0, 1'b0, "bp", x);

    // Isolation: operands and in_valid wiggle during RUN and DONE
    run_op(4'b1010, 4'b0011, 1'b0, 2, 1'b1, 1'b0, "iso", x);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    check("iso_no_second", 64'(quiet), 64'd1);

    // Reset mid-operation, with a non-zero result (Bout=1) already on the outputs
    run_op(4'b0011, 4'b0101, 1'b0, 0, 1'b0, 1'b0, "pre_rst", x);
    A = 4'b1001; B = 4'b0010; Bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);            // two RUN edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 64'({out_valid, in_ready, Bout, Diff}), 64'({1'b0, 1'b1, 1'b0, 4'b0000}));
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid || Diff != 4'b0000 || Bout) quiet = 1'b0;
    end
    check("rst_no_partial", 64'(quiet), 64'd1);

    // Operand offered on the very first edge after reset release
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0110, 4'b1001, 1'b1, 0, 1'b0, 1'b0, "post_rst", x);

    // Back-to-back random operations with out_ready held high throughout
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0, 1'b1, "b2b", x);
      if (i > 0) check("b2b_spacing", 64'(x - prev), 64'(W + 2));
      prev = x;
    end
    out_ready = 1'b0;

    // Random operations with random stalls and disturbance
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'b0, "rnd", x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
